// File: rtl/mem_access_arbiter.sv
// -----------------------------------------------------------------------------
// mem_access_arbiter
//
// Front-end for the single-port MemoryUnit (ROM + RAM). It arbitrates
// instruction fetches (if_*) and loads/stores (dm_*) round robin onto one
// WE/WD/ADDR port. It checks alignment and the address map, and returns read
// data or an error to whichever requester owns the transaction.
//
// Ports
//   clk, rst_n              clock (rising edge), synchronous active-low reset
//   if_req_i / if_addr_i    fetch request (read only) and its byte address
//   if_gnt_o                fetch accepted (combinational, IDLE only)
//   if_rvalid_o/_rdata_o/_err_o  fetch response, one-cycle pulse
//   dm_req_i/_we_i/_addr_i/_wdata_i  load/store request
//   dm_gnt_o                data request accepted (combinational, IDLE only)
//   dm_rvalid_o/_rdata_o/_err_o  data response, one-cycle pulse (loads and stores)
//   mem_we_o/_addr_o/_wd_o  to MemoryUnit WE_i / ADDR_i / WD_i
//   mem_rd_i                from MemoryUnit RD_o, RD_LAT cycles after ADDR
//
// Transaction timeline (grant cycle = 0):
//   error  : RESP in cycle 1, no memory activity
//   store  : ACCESS in cycle 1 (mem_we_o high), RESP in cycle 2
//   read   : ACCESS in cycle 1, WAIT for RD_LAT cycles, RESP in cycle 2+RD_LAT
// -----------------------------------------------------------------------------
module mem_access_arbiter #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  ROM_BASE   = 32'h0040_0000,
  parameter int unsigned            ROM_BYTES  = 256,
  parameter logic [DATA_WIDTH-1:0]  RAM_BASE   = 32'h1001_0000,
  parameter int unsigned            RAM_BYTES  = 256,
  parameter int unsigned            RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [DATA_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [DATA_WIDTH-1:0] if_rdata_o,
  output logic                  if_err_o,
  input  logic                  dm_req_i,
  input  logic                  dm_we_i,
  input  logic [DATA_WIDTH-1:0] dm_addr_i,
  input  logic [DATA_WIDTH-1:0] dm_wdata_i,
  output logic                  dm_gnt_o,
  output logic                  dm_rvalid_o,
  output logic [DATA_WIDTH-1:0] dm_rdata_o,
  output logic                  dm_err_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wd_o,
  input  logic [DATA_WIDTH-1:0] mem_rd_i
);

  // Region ends are computed one bit wider so that a region touching the top
  // of the address space is representable and wrap-around can be detected.
  localparam logic [DATA_WIDTH:0] ROM_LO   = {1'b0, ROM_BASE};
  localparam logic [DATA_WIDTH:0] ROM_HI   = {1'b0, ROM_BASE} + (DATA_WIDTH+1)'(ROM_BYTES);
  localparam logic [DATA_WIDTH:0] RAM_LO   = {1'b0, RAM_BASE};
  localparam logic [DATA_WIDTH:0] RAM_HI   = {1'b0, RAM_BASE} + (DATA_WIDTH+1)'(RAM_BYTES);
  localparam logic [DATA_WIDTH:0] SPAN_TOP = {1'b1, {DATA_WIDTH{1'b0}}};
  // Last WAIT count value; unused when RD_LAT is 0 (WAIT is skipped).
  localparam logic [1:0]          LAT_LAST = 2'(RD_LAT - 32'd1);

  if ((ROM_HI > SPAN_TOP) || (RAM_HI > SPAN_TOP) || (RD_LAT > 32'd3) ||
      ((ROM_BYTES % 32'd4) != 32'd0) || ((RAM_BYTES % 32'd4) != 32'd0)) begin : g_param_check
    $error("mem_access_arbiter: illegal parameters (region wraps, size not word multiple, or RD_LAT > 3)");
  end

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic                  owner_dm_q, owner_dm_d;   // 1 = data port owns the transaction
  logic                  store_q, store_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  last_dm_q, last_dm_d;     // 1 = data port was granted last
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wd_q, mem_wd_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  if_err_q, if_err_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  dm_rvalid_q, dm_rvalid_d;
  logic                  dm_err_q, dm_err_d;
  logic [DATA_WIDTH-1:0] dm_rdata_q, dm_rdata_d;

  logic                  if_gnt_s, dm_gnt_s;
  logic                  sel_dm_s;
  logic [DATA_WIDTH-1:0] req_addr_s;
  logic                  req_we_s;
  logic                  in_rom_s, in_ram_s;
  logic                  req_err_s;
  logic                  resp_s, resp_err_s, resp_rd_s, resp_dm_s;

  // Candidate selection and address checks for the request that would be granted now.
  always_comb begin
    // On a tie the port that was not granted last wins.
    sel_dm_s   = dm_req_i && (!if_req_i || !last_dm_q);
    req_addr_s = sel_dm_s ? dm_addr_i : if_addr_i;
    req_we_s   = sel_dm_s && dm_we_i;
    in_rom_s   = ({1'b0, req_addr_s} >= ROM_LO) && ({1'b0, req_addr_s} < ROM_HI);
    in_ram_s   = ({1'b0, req_addr_s} >= RAM_LO) && ({1'b0, req_addr_s} < RAM_HI);
    req_err_s  = (req_addr_s[1:0] != 2'b00) || (!in_rom_s && !in_ram_s) ||
                 (req_we_s && in_rom_s);
  end

  // Next-state, grant and response generation.
  always_comb begin
    state_d     = state_q;
    owner_dm_d  = owner_dm_q;
    store_d     = store_q;
    cnt_d       = cnt_q;
    last_dm_d   = last_dm_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wd_d    = mem_wd_q;
    if_rvalid_d = 1'b0;
    if_err_d    = 1'b0;
    if_rdata_d  = '0;
    dm_rvalid_d = 1'b0;
    dm_err_d    = 1'b0;
    dm_rdata_d  = '0;
    if_gnt_s    = 1'b0;
    dm_gnt_s    = 1'b0;
    resp_s      = 1'b0;
    resp_err_s  = 1'b0;
    resp_rd_s   = 1'b0;
    resp_dm_s   = owner_dm_q;

    case (state_q)
      ST_IDLE: begin
        // Grants are suppressed while reset is asserted so every output reads 0.
        if (rst_n && (if_req_i || dm_req_i)) begin
          if_gnt_s   = !sel_dm_s;
          dm_gnt_s   = sel_dm_s;
          last_dm_d  = sel_dm_s;
          owner_dm_d = sel_dm_s;
          if (req_err_s) begin
            // Faulty requests never touch the memory port.
            state_d    = ST_RESP;
            resp_s     = 1'b1;
            resp_err_s = 1'b1;
            resp_dm_s  = sel_dm_s;
          end else begin
            state_d    = ST_ACCESS;
            store_d    = req_we_s;
            mem_addr_d = req_addr_s;
            mem_we_d   = req_we_s;
            if (req_we_s) begin
              mem_wd_d = dm_wdata_i;
            end else begin
              mem_wd_d = mem_wd_q;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (store_q) begin
          state_d = ST_RESP;
          resp_s  = 1'b1;
        end else if (RD_LAT == 32'd0) begin
          state_d   = ST_RESP;
          resp_s    = 1'b1;
          resp_rd_s = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = 2'd0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d   = ST_RESP;
          resp_s    = 1'b1;
          resp_rd_s = 1'b1;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Route the response registers to the owning requester only.
    if (resp_s) begin
      if (resp_dm_s) begin
        dm_rvalid_d = 1'b1;
        dm_err_d    = resp_err_s;
        dm_rdata_d  = resp_rd_s ? mem_rd_i : '0;
      end else begin
        if_rvalid_d = 1'b1;
        if_err_d    = resp_err_s;
        if_rdata_d  = resp_rd_s ? mem_rd_i : '0;
      end
    end else begin
      dm_rvalid_d = 1'b0;
      if_rvalid_d = 1'b0;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      owner_dm_q  <= 1'b0;
      store_q     <= 1'b0;
      cnt_q       <= 2'd0;
      last_dm_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wd_q    <= '0;
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rvalid_q <= 1'b0;
      dm_err_q    <= 1'b0;
      dm_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_dm_q  <= owner_dm_d;
      store_q     <= store_d;
      cnt_q       <= cnt_d;
      last_dm_q   <= last_dm_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wd_q    <= mem_wd_d;
      if_rvalid_q <= if_rvalid_d;
      if_err_q    <= if_err_d;
      if_rdata_q  <= if_rdata_d;
      dm_rvalid_q <= dm_rvalid_d;
      dm_err_q    <= dm_err_d;
      dm_rdata_q  <= dm_rdata_d;
    end
  end

  assign if_gnt_o    = if_gnt_s;
  assign dm_gnt_o    = dm_gnt_s;
  assign if_rvalid_o = if_rvalid_q;
  assign if_err_o    = if_err_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rvalid_o = dm_rvalid_q;
  assign dm_err_o    = dm_err_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wd_o    = mem_wd_q;

endmodule
